dpram_port_arbiter: RTL

DPRAM_PORT_ARBITER -- requirements
Module: dpram_port_arbiter

---
 rtl/dpram_port_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/dpram_port_arbiter.sv
// Two-requester round-robin front end for one RAM port.
// Clears the memory after reset, then arbitrates single-cycle accesses.
module dpram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              init_busy
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              last;
  logic              rd_v;
  logic              rd_tag;
  logic              run;
  logic              sweep;

  // Reset gates the combinational outputs so they drop at once.
  assign run   = reset && (state == RUN);
  assign sweep = reset && (state == INIT);

  // last = 1 means requester 1 was granted most recently.
  assign gnt0 = run & req0 & (~req1 | last);
  assign gnt1 = run & req1 & (~req0 | ~last);

  assign init_busy = (state == INIT);

  assign rvalid0 = rd_v & ~rd_tag;
  assign rvalid1 = rd_v & rd_tag;
  assign rdata0  = rvalid0 ? ram_rdata : '0;
  assign rdata1  = rvalid1 ? ram_rdata : '0;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      sweep: begin
        ram_we   = 1'b1;
        ram_addr = cnt;
      end
      gnt0: begin
        ram_we    = we0;
        ram_addr  = addr0;
        ram_wdata = wdata0;
      end
      gnt1: begin
        ram_we    = we1;
        ram_addr  = addr1;
        ram_wdata = wdata1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= INIT;
      cnt    <= '0;
      last   <= 1'b1;
      rd_v   <= 1'b0;
      rd_tag <= 1'b0;
    end else begin
      rd_v   <= (gnt0 & ~we0) | (gnt1 & ~we1);
      rd_tag <= gnt1;
      unique case (state)
        INIT: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == LAST_ADDR)
            state <= RUN;
        end
        RUN: begin
          if (gnt0 | gnt1)
            last <= gnt1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
